lane_phase_scheduler: RTL and testbench

//  Timed phase sequencer for the four-lane intersection (NS1, NS2, EW1, EW2).
//  - Serves lanes with demand round-robin: GREEN, YELLOW, ALL_RED in turn.
//  - Green duration is set in ticks, with a bounded extension under congestion.
//  - Drives the 4-bit light_signal code used across the controller.
//  - Sits between the lane sensors (start S1, congestion S5) and the lamp drivers.

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/lane_rr_picker.sv | 27 ++
 rtl/lane_phase_scheduler.sv | 157 +++++++++++++++
 tb/tb_lane_phase_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: lane/phase encodings and the lamp code.
package traffic_pkg;

  localparam int unsigned LANE_W  = 2;
  localparam int unsigned LIGHT_W = 4;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10,
    PH_ALLRED = 2'b11
  } phase_e;

  // 0 = all red, GREEN = 2*lane+1, YELLOW = 2*lane+2
  function automatic logic [LIGHT_W-1:0] light_code(input logic [LANE_W-1:0] lane,
                                                    input phase_e ph);
    logic [LIGHT_W-1:0] base;
    base = {1'b0, lane, 1'b0};
    case (ph)
      PH_GREEN:  return base + 4'd1;
      PH_YELLOW: return base + 4'd2;
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/lane_rr_picker.sv
// Round-robin lane picker: first demanding lane after last_lane, wrapping mod 4.
module lane_rr_picker
  import traffic_pkg::*;
(
  input  logic [3:0]        demand,
  input  logic [LANE_W-1:0] last_lane,
  output logic              pick_valid,
  output logic [LANE_W-1:0] pick_lane
);

  logic [LANE_W-1:0] idx;

  // Scan from farthest to nearest so the nearest demanding lane overrides.
  always_comb begin
    pick_valid = 1'b0;
    pick_lane  = '0;
    idx        = '0;
    for (int i = 4; i >= 1; i--) begin
      idx = last_lane + LANE_W'(i);
      if (demand[idx]) begin
        pick_valid = 1'b1;
        pick_lane  = idx;
      end
    end
  end

endmodule

// File: rtl/lane_phase_scheduler.sv
// Four-lane GREEN/YELLOW/ALL_RED phase sequencer with congestion extension.
// Optional emergency preemption is built when EMERGENCY_PREEMPT_EN is defined.
module lane_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_T  = 10,
  parameter int unsigned EXT_T    = 5,
  parameter int unsigned MAX_EXT  = 1,
  parameter int unsigned YELLOW_T = 3,
  parameter int unsigned ALLRED_T = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [3:0]         demand,
  input  logic [3:0]         congest,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic               emerg_req,
  input  logic [LANE_W-1:0]  emerg_lane,
`endif
  output logic [LANE_W-1:0]  active_lane,
  output logic [1:0]         phase,
  output logic [LIGHT_W-1:0] light_signal,
  output logic               green_start,
  output logic               busy
);

  localparam int unsigned EXT_W = (MAX_EXT < 1) ? 1 : $clog2(MAX_EXT + 1);

  if (GREEN_T == 0 || EXT_T == 0 || YELLOW_T == 0 || ALLRED_T == 0) begin : g_bad_param
    $error("lane_phase_scheduler: timer parameters must be >= 1");
  end

  phase_e            state;
  logic [LANE_W-1:0] last_lane;
  logic [CNT_W-1:0]  timer;
  logic [EXT_W-1:0]  ext_cnt;

  logic              pick_valid;
  logic [LANE_W-1:0] pick_lane;
  logic              go_valid_c;
  logic [LANE_W-1:0] go_lane_c;
  logic              preempt_c;
  logic              hold_c;
  logic              expire_c;

  lane_rr_picker u_picker (
    .demand     (demand),
    .last_lane  (last_lane),
    .pick_valid (pick_valid),
    .pick_lane  (pick_lane)
  );

  // Target of the next green: emergency lane overrides round-robin when requested.
  always_comb begin
    go_valid_c = pick_valid;
    go_lane_c  = pick_lane;
    preempt_c  = 1'b0;
    hold_c     = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
    if (emerg_req) begin
      go_valid_c = 1'b1;
      go_lane_c  = emerg_lane;
      preempt_c  = (emerg_lane != active_lane);
      hold_c     = (emerg_lane == active_lane);
    end
`endif
  end

  assign expire_c = tick && (timer == CNT_W'(1));
  assign phase    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PH_IDLE;
      active_lane  <= '0;
      last_lane    <= LANE_W'(3);
      timer        <= '0;
      ext_cnt      <= '0;
      light_signal <= '0;
      green_start  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      green_start <= 1'b0;
      case (state)
        PH_IDLE: begin
          if (go_valid_c) begin
            state        <= PH_GREEN;
            active_lane  <= go_lane_c;
            last_lane    <= go_lane_c;
            timer        <= CNT_W'(GREEN_T);
            ext_cnt      <= '0;
            light_signal <= light_code(go_lane_c, PH_GREEN);
            green_start  <= 1'b1;
            busy         <= 1'b1;
          end
        end
        PH_GREEN: begin
          if (preempt_c) begin
            state        <= PH_YELLOW;
            timer        <= CNT_W'(YELLOW_T);
            light_signal <= light_code(active_lane, PH_YELLOW);
          end else if (tick && !hold_c) begin
            if (expire_c) begin
              if (congest[active_lane] && (ext_cnt < EXT_W'(MAX_EXT))) begin
                timer   <= CNT_W'(EXT_T);
                ext_cnt <= ext_cnt + EXT_W'(1);
              end else begin
                state        <= PH_YELLOW;
                timer        <= CNT_W'(YELLOW_T);
                light_signal <= light_code(active_lane, PH_YELLOW);
              end
            end else begin
              timer <= timer - CNT_W'(1);
            end
          end
        end
        PH_YELLOW: begin
          if (expire_c) begin
            state        <= PH_ALLRED;
            timer        <= CNT_W'(ALLRED_T);
            light_signal <= '0;
          end else if (tick) begin
            timer <= timer - CNT_W'(1);
          end
        end
        PH_ALLRED: begin
          if (expire_c) begin
            if (go_valid_c) begin
              state        <= PH_GREEN;
              active_lane  <= go_lane_c;
              last_lane    <= go_lane_c;
              timer        <= CNT_W'(GREEN_T);
              ext_cnt      <= '0;
              light_signal <= light_code(go_lane_c, PH_GREEN);
              green_start  <= 1'b1;
            end else begin
              state        <= PH_IDLE;
              timer        <= '0;
              light_signal <= '0;
              busy         <= 1'b0;
            end
          end else if (tick) begin
            timer <= timer - CNT_W'(1);
          end
        end
        default: begin
          state        <= PH_IDLE;
          light_signal <= '0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lane_phase_scheduler.sv
// Directed scoreboard bench for lane_phase_scheduler; emergency step built with EMERGENCY_PREEMPT_EN.
module tb_lane_phase_scheduler;

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] GRN = 2'b01;
  localparam logic [1:0] YEL = 2'b10;
  localparam logic [1:0] ARD = 2'b11;

  typedef struct packed {
    logic [1:0] ph;
    logic [1:0] lane;
    logic [3:0] light;
    logic       gs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] demand;
  logic [3:0] congest;
  logic [1:0] active_lane;
  logic [1:0] phase;
  logic [3:0] light_signal;
  logic       green_start;
  logic       busy;
`ifdef EMERGENCY_PREEMPT_EN
  logic       emerg_req;
  logic [1:0] emerg_lane;
`endif

  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;
  string tag    = "reset";

  always #5 clk = ~clk;

  lane_phase_scheduler #(
    .GREEN_T  (4),
    .EXT_T    (2),
    .MAX_EXT  (1),
    .YELLOW_T (2),
    .ALLRED_T (1),
    .CNT_W    (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .demand       (demand),
    .congest      (congest),
`ifdef EMERGENCY_PREEMPT_EN
    .emerg_req    (emerg_req),
    .emerg_lane   (emerg_lane),
`endif
    .active_lane  (active_lane),
    .phase        (phase),
    .light_signal (light_signal),
    .green_start  (green_start),
    .busy         (busy)
  );

  task automatic push_n(input int n, input logic [1:0] ph, input logic [1:0] lane,
                        input logic [3:0] light, input logic gs);
    exp_t e;
    e.ph = ph; e.lane = lane; e.light = light; e.gs = gs;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  // One clock, then compare the DUT against the oldest scoreboard entry.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s sb_empty observed=0 expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks += 5;
      assert (phase === e.ph) else begin
        errors++; $error("FAIL %s phase observed=%0d expected=%0d", tag, phase, e.ph);
      end
      assert (active_lane === e.lane) else begin
        errors++; $error("FAIL %s lane observed=%0d expected=%0d", tag, active_lane, e.lane);
      end
      assert (light_signal === e.light) else begin
        errors++; $error("FAIL %s light observed=%0d expected=%0d", tag, light_signal, e.light);
      end
      assert (green_start === e.gs) else begin
        errors++; $error("FAIL %s green_start observed=%0b expected=%0b", tag, green_start, e.gs);
      end
      assert (busy === (e.ph != IDL)) else begin
        errors++; $error("FAIL %s busy observed=%0b expected=%0b", tag, busy, (e.ph != IDL));
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b1; demand = 4'b0000; congest = 4'b0000;
`ifdef EMERGENCY_PREEMPT_EN
    emerg_req = 1'b0; emerg_lane = 2'd0;
`endif
    push_n(1, IDL, 2'd0, 4'd0, 1'b0);
    run(1);
    rst = 1'b0;

    tag = "idle_no_demand";
    push_n(20, IDL, 2'd0, 4'd0, 1'b0);
    run(20);

    tag = "rr_0101";
    demand = 4'b0101;
    push_n(1, GRN, 2'd0, 4'd1, 1'b1);
    push_n(3, GRN, 2'd0, 4'd1, 1'b0);
    push_n(2, YEL, 2'd0, 4'd2, 1'b0);
    push_n(1, ARD, 2'd0, 4'd0, 1'b0);
    push_n(1, GRN, 2'd2, 4'd5, 1'b1);
    run(8);
    demand = 4'b0000;
    push_n(3, GRN, 2'd2, 4'd5, 1'b0);
    push_n(2, YEL, 2'd2, 4'd6, 1'b0);
    push_n(1, ARD, 2'd2, 4'd0, 1'b0);
    push_n(1, IDL, 2'd2, 4'd0, 1'b0);
    run(7);

    tag = "congest_ext";
    demand = 4'b0001; congest = 4'b0001;
    push_n(1, GRN, 2'd0, 4'd1, 1'b1);
    run(1);
    demand = 4'b0000;
    push_n(5, GRN, 2'd0, 4'd1, 1'b0);
    push_n(2, YEL, 2'd0, 4'd2, 1'b0);
    push_n(1, ARD, 2'd0, 4'd0, 1'b0);
    push_n(1, IDL, 2'd0, 4'd0, 1'b0);
    run(9);
    congest = 4'b0000;

    tag = "lone_lane3";
    demand = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      push_n(1, GRN, 2'd3, 4'd7, 1'b1);
      push_n(3, GRN, 2'd3, 4'd7, 1'b0);
      push_n(2, YEL, 2'd3, 4'd8, 1'b0);
      push_n(1, ARD, 2'd3, 4'd0, 1'b0);
      run(7);
    end
    demand = 4'b0000;
    push_n(1, IDL, 2'd3, 4'd0, 1'b0);
    run(1);

    tag = "rst_mid_yellow";
    demand = 4'b1111;
    push_n(1, GRN, 2'd0, 4'd1, 1'b1);
    push_n(3, GRN, 2'd0, 4'd1, 1'b0);
    push_n(2, YEL, 2'd0, 4'd2, 1'b0);
    push_n(1, ARD, 2'd0, 4'd0, 1'b0);
    push_n(1, GRN, 2'd1, 4'd3, 1'b1);
    push_n(3, GRN, 2'd1, 4'd3, 1'b0);
    push_n(1, YEL, 2'd1, 4'd4, 1'b0);
    run(12);
    rst = 1'b1;
    push_n(1, IDL, 2'd0, 4'd0, 1'b0);
    run(1);
    rst = 1'b0;
    push_n(1, GRN, 2'd0, 4'd1, 1'b1);
    run(1);
    demand = 4'b0000;
    push_n(3, GRN, 2'd0, 4'd1, 1'b0);
    push_n(2, YEL, 2'd0, 4'd2, 1'b0);
    push_n(1, ARD, 2'd0, 4'd0, 1'b0);
    push_n(1, IDL, 2'd0, 4'd0, 1'b0);
    run(7);

`ifdef EMERGENCY_PREEMPT_EN
    tag = "emergency";
    demand = 4'b0001; emerg_lane = 2'd2;
    push_n(1, GRN, 2'd0, 4'd1, 1'b1);
    push_n(1, GRN, 2'd0, 4'd1, 1'b0);
    run(2);
    emerg_req = 1'b1;
    push_n(2, YEL, 2'd0, 4'd2, 1'b0);
    push_n(1, ARD, 2'd0, 4'd0, 1'b0);
    push_n(1, GRN, 2'd2, 4'd5, 1'b1);
    push_n(4, GRN, 2'd2, 4'd5, 1'b0);
    run(8);
    emerg_req = 1'b0;
    push_n(3, GRN, 2'd2, 4'd5, 1'b0);
    push_n(2, YEL, 2'd2, 4'd6, 1'b0);
    push_n(1, ARD, 2'd2, 4'd0, 1'b0);
    push_n(1, GRN, 2'd0, 4'd1, 1'b1);
    run(7);
    demand = 4'b0000;
    push_n(3, GRN, 2'd0, 4'd1, 1'b0);
    push_n(2, YEL, 2'd0, 4'd2, 1'b0);
    push_n(1, ARD, 2'd0, 4'd0, 1'b0);
    push_n(1, IDL, 2'd0, 4'd0, 1'b0);
    run(7);
`endif

    tag = "drain";
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL %s sb_leftover observed=%0d expected=0", tag, sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
